simd_drain: RTL and testbench
=============================

SIMD_DRAIN -- requirements
Module: simd_drain

Interface
REQ-001 Parameter DIM_A, default 32, number of input lanes per weight column.
REQ-002 Parameter DIM_C, default 4, number of weight columns.
REQ-003 Parameter ACC_WIDTH, default 16, width of one product word.
REQ-004 Parameter INPUT_WIDTH, default 8, temporal window is 2**INPUT_WIDTH enabled cycles.
REQ-005 Parameter SNAP_DELAY, default 2, cycles from window wrap to snapshot; legal range is 1 to 8.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 enable  in  1  window-advance strobe, same signal that drives the SIMD cell.
REQ-009 product_reg  in  [DIM_C][DIM_A][ACC_WIDTH]  product array from the SIMD cell.
REQ-010 out_valid  out  1  a drained word is presented.
REQ-011 out_ready  in  1  consumer accepts the word on valid&ready.
REQ-012 out_data  out  ACC_WIDTH  drained product word.
REQ-013 out_c  out  clog2(DIM_C)  column index of out_data.
REQ-014 out_a  out  clog2(DIM_A)  lane index of out_data.
REQ-015 out_last  out  1  high with the final word of a snapshot.
REQ-016 busy  out  1  high while in state DRAIN.
REQ-017 overrun  out  1  sticky flag: a snapshot was dropped.

Function
REQ-018 Window counter: INPUT_WIDTH bits, +1 on enable=1, holds on enable=0, wraps 2**INPUT_WIDTH-1 -> 0.
REQ-019 Wrap event: the cycle with enable=1 and counter=2**INPUT_WIDTH-1.
REQ-020 snap_pulse: the wrap event delayed by exactly SNAP_DELAY cycles through a delay line that shifts every cycle, independent of enable.
REQ-021 FSM states: IDLE and DRAIN; the reset state is IDLE.
REQ-022 IDLE with snap_pulse: capture all of product_reg into the snapshot buffer, set indices c=0 and a=0, go to DRAIN.
REQ-023 DRAIN: out_valid=1; out_data=snapshot[out_c][out_a]; out_last=1 exactly when c=DIM_C-1 and a=DIM_A-1.
REQ-024 Drain order: a is the inner index (0..DIM_A-1) and c is the outer index; one word is accepted per valid&ready; total DIM_C*DIM_A words.
REQ-025 With valid=1 and ready=0: out_data, out_c, out_a and out_last stay stable.
REQ-026 Last-word handshake without snap_pulse: go to IDLE, out_valid=0 in the next cycle.
REQ-027 Snap_pulse in DRAIN, not on the last-word handshake: do not overwrite the snapshot; set overrun=1; the drain continues unaffected.
REQ-028 Snap_pulse on the same cycle as the last-word handshake: capture the new snapshot, reset indices to 0, stay in DRAIN; overrun is not set.
REQ-029 Only rst clears overrun.
REQ-030 Latency: the first word is valid in the cycle after snap_pulse; with ready held at 1 the drain lasts DIM_C*DIM_A cycles, back-to-back.

Reset
REQ-031 When rst=1 at a clock edge, the following are cleared to 0: window counter, delay line, snapshot buffer, indices, out_valid, out_last, out_data, busy and overrun; the FSM goes to IDLE.
REQ-032 Reset mid-drain abandons the drain, the snapshot and any pending pulses in the delay line; the next window counts from 0.

Structure
REQ-033 Package tlut_pkg holds DIM_A, DIM_C, ACC_WIDTH and INPUT_WIDTH defaults, the product_array_t typedef and the drain_state_t enum {IDLE, DRAIN}.
REQ-034 The window counter plus delay line is one sub-module, window_cnt, with outputs cnt and snap_pulse.
REQ-035 The snapshot buffer and FSM stay in simd_drain.

Verification (defaults; window = 256 enabled cycles)
REQ-036 Stimulus: rst, then enable=1 and ready=1 continuously, with product_reg[c][a]=c*256+a. Required: snap_pulse two cycles after counter=255; 128 words in order 0,1,..,31,256,..,799; out_last only on word 128 (value 799).
REQ-037 Stimulus: ready toggles 1,0 every cycle during a drain. Required: outputs held during stall cycles; exactly 128 accepted words, in order, with no duplicates.
REQ-038 Stimulus: ready=0 across two windows, product_reg changed to all 0xFFFF after the first snap. Required: overrun=1 one cycle after the second snap_pulse; after ready=1 the drained data is the first snapshot.
REQ-039 Stimulus: ready timed so the last-word handshake coincides with snap_pulse. Required: overrun stays 0; the next cycle shows out_valid=1, out_c=0, out_a=0, with new data.
REQ-040 Stimulus: rst asserted after word 40 of a drain. Required: out_valid=0, busy=0, overrun=0 in the next cycle; the next snap_pulse comes 256 enabled cycles plus 2 cycles later.
REQ-041 Stimulus: enable=0 for 10 cycles mid-window. Required: snap_pulse delayed by exactly 10 cycles compared with continuous enable.

Source files
------------

// File: rtl/tlut_pkg.sv
// Shared defaults and types for the product-array drain logic.
package tlut_pkg;

    localparam int DIM_A       = 32;
    localparam int DIM_C       = 4;
    localparam int ACC_WIDTH   = 16;
    localparam int INPUT_WIDTH = 8;

    typedef logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] product_array_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/window_cnt.sv
// Temporal window counter with a fixed-length delay line that turns the
// window wrap into a snapshot strobe a few cycles later.
module window_cnt #(
    parameter int INPUT_WIDTH = 8,
    parameter int SNAP_DELAY  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    output logic [INPUT_WIDTH-1:0] cnt,
    output logic                   snap_pulse
);

    logic                  wrap;
    logic [SNAP_DELAY-1:0] dline;

    assign wrap       = enable && (cnt == '1);
    assign snap_pulse = dline[SNAP_DELAY-1];

    // Window position advances only on enabled cycles and wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The delay line shifts every cycle so the snapshot lands a fixed time
    // after the wrap regardless of later enable activity.
    generate
        if (SNAP_DELAY == 1) begin : g_dline_one
            always_ff @(posedge clk) begin
                if (rst) begin
                    dline <= '0;
                end else begin
                    dline <= wrap;
                end
            end
        end else begin : g_dline_many
            always_ff @(posedge clk) begin
                if (rst) begin
                    dline <= '0;
                end else begin
                    dline <= {dline[SNAP_DELAY-2:0], wrap};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/simd_drain.sv
// Snapshots the SIMD product array at each window wrap and drains it one
// word at a time over a valid/ready stream.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no snapshot pending; waiting for snap_pulse
//   DRAIN | presenting snapshot[c][a]; advancing on each accepted word
module simd_drain
    import tlut_pkg::*;
#(
    parameter int DIM_A       = tlut_pkg::DIM_A,
    parameter int DIM_C       = tlut_pkg::DIM_C,
    parameter int ACC_WIDTH   = tlut_pkg::ACC_WIDTH,
    parameter int INPUT_WIDTH = tlut_pkg::INPUT_WIDTH,
    parameter int SNAP_DELAY  = 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        enable,
    input  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0]  product_reg,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [ACC_WIDTH-1:0]                        out_data,
    output logic [$clog2(DIM_C)-1:0]                    out_c,
    output logic [$clog2(DIM_A)-1:0]                    out_a,
    output logic                                        out_last,
    output logic                                        busy,
    output logic                                        overrun
);

    localparam int CW = $clog2(DIM_C);
    localparam int AW = $clog2(DIM_A);

    logic                                       snap_pulse;
    drain_state_t                               state;
    drain_state_t                               state_nxt;
    logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] snapshot;
    logic [CW-1:0]                              idx_c;
    logic [AW-1:0]                              idx_a;
    logic                                       at_last;
    logic                                       capture;
    logic                                       advance;
    logic                                       set_ovr;

    window_cnt #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .SNAP_DELAY  (SNAP_DELAY)
    ) u_win (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cnt        (),
        .snap_pulse (snap_pulse)
    );

    assign at_last   = (idx_c == CW'(DIM_C - 1)) && (idx_a == AW'(DIM_A - 1));
    assign busy      = (state == DRAIN);
    assign out_valid = busy;
    assign out_last  = busy && at_last;
    assign out_data  = snapshot[idx_c][idx_a];
    assign out_c     = idx_c;
    assign out_a     = idx_a;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath controls; a pulse arriving together with the
    // final handshake chains straight into the next drain instead of being lost.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        advance   = 1'b0;
        set_ovr   = 1'b0;
        case (state)
            IDLE: begin
                if (snap_pulse) begin
                    capture   = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (at_last) begin
                        if (snap_pulse) begin
                            capture = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
                if (snap_pulse && !(out_ready && at_last)) begin
                    set_ovr = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot buffer, drain indices (lane inner, column outer) and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            snapshot <= '0;
            idx_c    <= '0;
            idx_a    <= '0;
            overrun  <= 1'b0;
        end else begin
            if (capture) begin
                snapshot <= product_reg;
                idx_c    <= '0;
                idx_a    <= '0;
            end else if (advance) begin
                if (idx_a == AW'(DIM_A - 1)) begin
                    idx_a <= '0;
                    idx_c <= idx_c + 1'b1;
                end else begin
                    idx_a <= idx_a + 1'b1;
                end
            end
            if (set_ovr) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_simd_drain.sv
// Bench for simd_drain: a queue-based reference model tracks window wraps,
// pending snapshots and the expected word stream; scenarios come from a table
// plus a few hand-built corner sequences.
module tb_simd_drain;

    localparam int DA     = 32;
    localparam int DC     = 4;
    localparam int AW     = 16;
    localparam int WIN    = 256;
    localparam int SNAP_D = 2;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          enable;
    logic                          out_ready;
    logic [DC-1:0][DA-1:0][AW-1:0] product_reg;
    logic                          out_valid;
    logic [AW-1:0]                 out_data;
    logic [1:0]                    out_c;
    logic [4:0]                    out_a;
    logic                          out_last;
    logic                          busy;
    logic                          overrun;

    always #5 clk = ~clk;

    simd_drain dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .product_reg (product_reg),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_c       (out_c),
        .out_a       (out_a),
        .out_last    (out_last),
        .busy        (busy),
        .overrun     (overrun)
    );

    typedef struct {
        logic [AW-1:0] data;
        int            c;
        int            a;
        bit            last;
    } word_t;

    typedef struct {
        string name;
        int    en_mode;
        int    rdy_mode;
        int    data_mode;
        int    cycles;
        int    exp_words;
        int    exp_ovr;
        int    exp_rise;
    } scn_t;

    word_t exp_q[$];
    int    due_q[$];
    int    cyc        = 0;
    int    wcnt       = 0;
    bit    m_ovr      = 1'b0;
    int    n_chk      = 0;
    int    n_err      = 0;
    int    dut_acc    = 0;
    int    first_rise = -1;
    bit    prev_valid = 1'b0;
    int    rst_cyc    = 0;
    int    acc0       = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        bit ev;
        ev = (exp_q.size() > 0);
        chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
        chk("busy", {31'b0, busy}, {31'b0, ev});
        chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
        if (ev) begin
            chk("out_data", {16'b0, out_data}, {16'b0, exp_q[0].data});
            chk("out_c", {30'b0, out_c}, exp_q[0].c);
            chk("out_a", {27'b0, out_a}, exp_q[0].a);
            chk("out_last", {31'b0, out_last}, {31'b0, exp_q[0].last});
        end else begin
            chk("out_last_idle", {31'b0, out_last}, 32'd0);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) dut_acc++;
        if (out_valid === 1'b1 && !prev_valid && first_rise < 0) first_rise = cyc;
        prev_valid = (out_valid === 1'b1);
    endtask

    // Reference: a wrap schedules a snapshot SNAP_D cycles later; a snapshot
    // loads the whole array into the expected stream if the stream is empty
    // (after this cycle's handshake), otherwise it is dropped and flagged.
    task automatic model_update(input bit r, input bit e, input bit rd);
        bit    snap;
        word_t w;
        if (r) begin
            wcnt = 0;
            due_q.delete();
            exp_q.delete();
            m_ovr = 1'b0;
        end else begin
            snap = (due_q.size() > 0) && (due_q[0] == cyc);
            if (snap) void'(due_q.pop_front());
            if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
            if (snap) begin
                if (exp_q.size() == 0) begin
                    for (int c = 0; c < DC; c++) begin
                        for (int a = 0; a < DA; a++) begin
                            w.data = product_reg[c][a];
                            w.c    = c;
                            w.a    = a;
                            w.last = (c == DC - 1) && (a == DA - 1);
                            exp_q.push_back(w);
                        end
                    end
                end else begin
                    m_ovr = 1'b1;
                end
            end
            if (e) begin
                if (wcnt == WIN - 1) due_q.push_back(cyc + SNAP_D);
                wcnt = (wcnt + 1) % WIN;
            end
        end
        cyc++;
    endtask

    task automatic set_prod(input int mode, input int rel);
        for (int c = 0; c < DC; c++) begin
            for (int a = 0; a < DA; a++) begin
                case (mode)
                    0:       product_reg[c][a] = AW'(c * 256 + a);
                    1:       product_reg[c][a] = (rel <= 258) ? AW'(c * 256 + a) : 16'hFFFF;
                    2:       product_reg[c][a] = AW'($urandom);
                    default: product_reg[c][a] = (rel <= 258) ? AW'(c * 256 + a)
                                                               : AW'(c * 256 + a + 16'h4000);
                endcase
            end
        end
    endtask

    function automatic bit en_of(input int mode, input int rel);
        case (mode)
            0:       return 1'b1;
            1:       return rel <= 256;
            2:       return $urandom_range(3, 0) != 0;
            default: return !(rel >= 100 && rel <= 109);
        endcase
    endfunction

    function automatic bit rdy_of(input int mode, input int rel);
        case (mode)
            0:       return 1'b1;
            1:       return (rel % 2) == 1;
            2:       return rel > 520;
            3:       return $urandom_range(2, 0) != 0;
            default: return rel >= 387;
        endcase
    endfunction

    task automatic step(input bit r, input bit e, input bit rd);
        rst       = r;
        enable    = e;
        out_ready = rd;
        @(negedge clk);
        check_outputs();
        model_update(r, e, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input int en_m, input int rdy_m, input int data_m, input int n, input bit do_rst);
        if (do_rst) begin
            rst_cyc = cyc;
            set_prod(data_m, 0);
            step(1'b1, 1'b0, 1'b0);
            first_rise = -1;
            acc0       = dut_acc;
        end
        for (int rel = 1; rel <= n; rel++) begin
            set_prod(data_m, rel);
            step(1'b0, en_of(en_m, rel), rdy_of(rdy_m, rel));
        end
    endtask

    scn_t scns[5];

    initial begin
        scns[0] = '{"stream",  0, 0, 0,  400, 128,  0, 259};
        scns[1] = '{"toggle",  1, 1, 0,  600, 128,  0, 259};
        scns[2] = '{"overrun", 0, 2, 1,  700, 128,  1, 259};
        scns[3] = '{"random",  2, 3, 2, 3000,  -1, -1,  -1};
        scns[4] = '{"multi",   0, 0, 2, 1100, 458,  0, 259};

        rst         = 1'b1;
        enable      = 1'b0;
        out_ready   = 1'b0;
        product_reg = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            run_seq(scns[i].en_mode, scns[i].rdy_mode, scns[i].data_mode, scns[i].cycles, 1'b1);
            if (scns[i].exp_words >= 0)
                chk({scns[i].name, "_words"}, dut_acc - acc0, scns[i].exp_words);
            if (scns[i].exp_ovr >= 0)
                chk({scns[i].name, "_overrun"}, {31'b0, overrun}, scns[i].exp_ovr);
            if (scns[i].exp_rise >= 0)
                chk({scns[i].name, "_first_valid"}, first_rise - rst_cyc, scns[i].exp_rise);
        end

        // Last-word handshake lands on the second snap_pulse.
        run_seq(0, 4, 3, 514, 1'b1);
        chk("chain_valid", {31'b0, out_valid}, 32'd1);
        chk("chain_c", {30'b0, out_c}, 32'd0);
        chk("chain_a", {27'b0, out_a}, 32'd0);
        chk("chain_data", {16'b0, out_data}, 32'h4000);
        chk("chain_overrun", {31'b0, overrun}, 32'd0);
        chk("chain_words", dut_acc - acc0, 32'd128);
        run_seq(0, 0, 3, 20, 1'b0);

        // Reset after 40 words, then a fresh window from zero.
        run_seq(0, 0, 0, 298, 1'b1);
        chk("rst_mid_words", dut_acc - acc0, 32'd40);
        rst_cyc = cyc;
        step(1'b1, 1'b1, 1'b1);
        first_rise = -1;
        chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_overrun", {31'b0, overrun}, 32'd0);
        run_seq(0, 0, 0, 300, 1'b0);
        chk("rst_mid_next_valid", first_rise - rst_cyc, 32'd259);

        // Ten disabled cycles mid-window push the snapshot out by ten.
        run_seq(3, 0, 0, 300, 1'b1);
        chk("gap_first_valid", first_rise - rst_cyc, 32'd269);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
